// File: rtl/dut_test_sequencer_if.sv
// Handshake/bus bundle between the test sequencer (master) and its host loader,
// stimulus source and DUT-interface FIFOs (slave).
interface dut_test_sequencer_if #(
  parameter int unsigned STF_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DIF_WIDTH = 32
);
  logic                 desc_valid;
  logic                 desc_ready;
  logic [STF_WIDTH-1:0] desc_mux;
  logic [CNT_WIDTH-1:0] desc_count;
  logic                 desc_pll;
  logic [DIF_WIDTH-1:0] dififo_data;
  logic                 dififo_wrreq;
  logic                 dififo_wrfull;
  logic [STF_WIDTH-1:0] vec_data;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [STF_WIDTH-1:0] sfifo_data;
  logic                 sfifo_wrreq;
  logic                 sfifo_wrfull;
  logic                 res_strobe;

  modport master (
    input  desc_valid, desc_mux, desc_count, desc_pll, dififo_wrfull,
           vec_data, vec_valid, sfifo_wrfull, res_strobe,
    output desc_ready, dififo_data, dififo_wrreq, vec_ready, sfifo_data, sfifo_wrreq
  );

  modport slave (
    output desc_valid, desc_mux, desc_count, desc_pll, dififo_wrfull,
           vec_data, vec_valid, sfifo_wrfull, res_strobe,
    input  desc_ready, dififo_data, dififo_wrreq, vec_ready, sfifo_data, sfifo_wrreq
  );
endinterface

// File: rtl/dut_test_sequencer.sv
// Runs one DUT test per descriptor: mux config write, clock-source settle, stimulus
// streaming, result drain. Optional SEQ_STATS_EN adds a per-test cycle counter.
module dut_test_sequencer #(
  parameter int unsigned STF_WIDTH      = 24,
  parameter int unsigned REQ_WIDTH      = 3,
  parameter int unsigned CMD_WIDTH      = 5,
  parameter int unsigned DIF_WIDTH      = REQ_WIDTH + CMD_WIDTH + STF_WIDTH,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  dut_test_sequencer_if.master bus,
  output logic                 pll_switch,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
`ifdef SEQ_STATS_EN
  ,
  output logic [31:0]          test_cycles
`endif
);

  localparam int unsigned SetW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCfgMux = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StStream = 3'd3;
  localparam logic [2:0] StDrain  = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [STF_WIDTH-1:0] mux_q, mux_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 pll_q, pll_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [CNT_WIDTH-1:0] res_q, res_d;
  logic [SetW-1:0]      settle_q, settle_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 pll_sw_q, pll_sw_d;
  logic                 err_q, err_d;
  logic                 accept;

  always_comb begin
    state_d  = state_q;
    mux_d    = mux_q;
    count_d  = count_q;
    pll_d    = pll_q;
    sent_d   = sent_q;
    res_d    = res_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    pll_sw_d = pll_sw_q;
    err_d    = err_q;
    accept   = 1'b0;

    bus.desc_ready   = 1'b0;
    bus.dififo_wrreq = 1'b0;
    bus.dififo_data  = DIF_WIDTH'({REQ_WIDTH'(0), CMD_WIDTH'(1), mux_q});
    bus.vec_ready    = 1'b0;
    bus.sfifo_wrreq  = 1'b0;
    bus.sfifo_data   = bus.vec_data;

    // Results saturate at N; anything outside STREAM/DRAIN is ignored.
    if ((state_q == StStream || state_q == StDrain) && bus.res_strobe && (res_q < count_q)) begin
      res_d = res_q + CNT_WIDTH'(1);
    end

    case (state_q)
      StIdle: begin
        bus.desc_ready = 1'b1;
        if (bus.desc_valid) begin
          accept  = 1'b1;
          mux_d   = bus.desc_mux;
          count_d = bus.desc_count;
          pll_d   = bus.desc_pll;
          sent_d  = '0;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = StCfgMux;
        end
      end
      StCfgMux: begin
        if (!bus.dififo_wrfull) begin
          bus.dififo_wrreq = 1'b1;
          pll_sw_d = pll_q;
          settle_d = (pll_q != pll_sw_q) ? SetW'(SETTLE_CYCLES) : '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = (count_q == '0) ? StDone : StStream;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      StStream: begin
        tmo_d = TmoW'(1);
        if (bus.vec_valid && !bus.sfifo_wrfull && (sent_q < count_q)) begin
          bus.vec_ready   = 1'b1;
          bus.sfifo_wrreq = 1'b1;
          sent_d = sent_q + CNT_WIDTH'(1);
          if (sent_d == count_q) state_d = StDrain;
        end
      end
      StDrain: begin
        // A strobe landing on the expiry cycle restarts the timer instead of timing out.
        if (res_d == count_q) begin
          state_d = StDone;
        end else if (bus.res_strobe) begin
          tmo_d = TmoW'(1);
        end else if (tmo_q >= TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // No FIFO writes or pops while reset is held, even in the cycle it is first seen.
    if (reset) begin
      bus.desc_ready   = 1'b0;
      bus.dififo_wrreq = 1'b0;
      bus.vec_ready    = 1'b0;
      bus.sfifo_wrreq  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mux_q    <= '0;
      count_q  <= '0;
      pll_q    <= 1'b0;
      sent_q   <= '0;
      res_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      pll_sw_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mux_q    <= mux_d;
      count_q  <= count_d;
      pll_q    <= pll_d;
      sent_q   <= sent_d;
      res_q    <= res_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      pll_sw_q <= pll_sw_d;
      err_q    <= err_d;
    end
  end

  assign pll_switch  = pll_sw_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err_timeout = err_q;

`ifdef SEQ_STATS_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (accept) begin
      cycles_d = '0;
    end else if (state_q != StIdle && state_q != StDone && cycles_q != '1) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign test_cycles = cycles_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Randomized bench for dut_test_sequencer: source/FIFO/result environment plus a
// per-test expectation model built from the descriptor and the stimulus pool.
module tb_dut_test_sequencer;

  localparam int unsigned Stf    = 24;
  localparam int unsigned Cnt    = 16;
  localparam int unsigned Settle = 16;
  localparam int unsigned Tmo    = 20;

  logic clock = 1'b0;
  logic reset;
  logic pll_switch, busy, done, err_timeout;
`ifdef SEQ_STATS_EN
  logic [31:0] test_cycles;
`endif

  always #5 clock = ~clock;

  dut_test_sequencer_if #(.STF_WIDTH(Stf), .CNT_WIDTH(Cnt), .DIF_WIDTH(32)) bus ();

  dut_test_sequencer #(
    .STF_WIDTH(Stf), .CNT_WIDTH(Cnt), .SETTLE_CYCLES(Settle), .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .pll_switch(pll_switch),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout)
`ifdef SEQ_STATS_EN
    ,
    .test_cycles(test_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment state
  logic [Stf-1:0] vec_pool [256];
  logic [Stf-1:0] sf_got[$];
  logic [31:0]    df_got[$];
  int             strobe_q[$];
  int cyc = 0;
  int vec_head = 0;
  int res_budget = 0;
  int valid_pct = 100;
  int sful_left = 0;
  int dful_left = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int df_cyc = 0;
  int first_sf_cyc = -1;
  int pll_chg_cyc = 0;
  int last_strobe_cyc = 0;
  logic pll_prev = 1'b0;
  logic model_pll = 1'b0;

  // Driver: source head, FIFO-full windows and delayed result strobes.
  initial begin
    bus.vec_valid = 1'b0; bus.vec_data = '0; bus.sfifo_wrfull = 1'b0;
    bus.dififo_wrfull = 1'b0; bus.res_strobe = 1'b0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      bus.vec_data  = vec_pool[vec_head % 256];
      bus.vec_valid = (valid_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < valid_pct);
      if (sful_left > 0 && sf_got.size() >= 2) begin
        bus.sfifo_wrfull = 1'b1; sful_left--;
      end else bus.sfifo_wrfull = 1'b0;
      if (dful_left > 0 && busy) begin
        bus.dififo_wrfull = 1'b1; dful_left--;
      end else bus.dififo_wrfull = 1'b0;
      bus.res_strobe = 1'b0;
      while (strobe_q.size() > 0 && strobe_q[0] <= cyc) begin
        void'(strobe_q.pop_front());
        bus.res_strobe = 1'b1;
        last_strobe_cyc = cyc;
      end
    end
  end

  // Monitor: samples at negedge, records writes and checks handshake rules.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.dififo_wrreq) begin
        chk_eq("df_while_full", bus.dififo_wrfull, 0);
        df_got.push_back(bus.dififo_data);
        df_cyc = cyc;
      end
      if (bus.vec_ready || bus.sfifo_wrreq) chk_eq("pop_eq_wr", bus.vec_ready, bus.sfifo_wrreq);
      if (bus.sfifo_wrreq) begin
        chk_eq("sf_while_full", bus.sfifo_wrfull, 0);
        chk_eq("sf_valid", bus.vec_valid, 1);
        sf_got.push_back(bus.sfifo_data);
        if (sf_got.size() == 1) first_sf_cyc = cyc;
        vec_head++;
        if (res_budget > 0) begin
          strobe_q.push_back(cyc + 3);
          res_budget--;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pll_switch !== pll_prev) begin
        pll_chg_cyc = cyc;
        pll_prev = pll_switch;
      end
    end
  end

  task automatic run_test(input logic [Stf-1:0] mux, input int count, input logic pll,
                          input int nres, input int vpct, input int sful, input int dful);
    int   t_head;
    logic chg;
    logic exp_err;
    sf_got.delete(); df_got.delete();
    done_cnt = 0; first_sf_cyc = -1;
    res_budget = nres; valid_pct = vpct; sful_left = sful; dful_left = dful;
    chg = (pll != model_pll);
    exp_err = (nres < count);
    @(posedge clock); #2;
    t_head = vec_head;
    bus.desc_mux = mux; bus.desc_count = Cnt'(count); bus.desc_pll = pll; bus.desc_valid = 1'b1;
    @(posedge clock); #2;
    bus.desc_valid = 1'b0; bus.desc_mux = Stf'($urandom); bus.desc_count = Cnt'($urandom);
    bus.desc_pll = ~pll;
    @(negedge clock); #1;
    chk_eq("err_clr_on_accept", err_timeout, 0);
    chk_eq("busy_after_accept", busy, 1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clock); #1;
    end
    chk_eq("done_seen", done_cnt != 0, 1);
    repeat (6) begin
      @(negedge clock); #1;
    end
    chk_eq("done_once", done_cnt, 1);
    chk_eq("df_writes", df_got.size(), 1);
    if (df_got.size() > 0) chk_eq("df_word", df_got[0], {8'h01, mux});
    chk_eq("sf_writes", sf_got.size(), count);
    for (int i = 0; i < sf_got.size() && i < count; i++) begin
      chk_eq("sf_data", sf_got[i], vec_pool[(t_head + i) % 256]);
    end
    chk_eq("err_timeout", err_timeout, exp_err);
    chk_eq("pll_switch", pll_switch, pll);
    chk_eq("idle_busy", busy, 0);
    chk_eq("idle_ready", bus.desc_ready, 1);
    if (chg) chk_eq("pll_on_settle_entry", pll_chg_cyc - df_cyc, 1);
    if (count > 0 && first_sf_cyc >= 0) begin
      if (chg) chk_eq("settle_wait", (first_sf_cyc - pll_chg_cyc) >= int'(Settle), 1);
      else if (vpct >= 100) chk_eq("no_settle_wait", (first_sf_cyc - df_cyc) <= 3, 1);
    end
    if (count == 0 && !chg) chk_eq("zero_done_fast", (done_cyc - df_cyc) <= 3, 1);
    if (exp_err && nres > 0) chk_eq("timeout_latency", done_cyc - last_strobe_cyc, Tmo);
    model_pll = pll;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    for (int i = 0; i < 256; i++) vec_pool[i] = Stf'($urandom);
    reset = 1'b1;
    bus.desc_valid = 1'b0; bus.desc_mux = '0; bus.desc_count = '0; bus.desc_pll = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_err", err_timeout, 0);
    chk_eq("rst_pll", pll_switch, 0);
    chk_eq("rst_dfwr", bus.dififo_wrreq, 0);
    chk_eq("rst_sfwr", bus.sfifo_wrreq, 0);
    chk_eq("rst_ready", bus.desc_ready, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock); #1;
    chk_eq("post_rst_ready", bus.desc_ready, 1);

    run_test(24'h000001, 4, 1'b0, 4, 100, 0, 0);
    run_test(Stf'($urandom), 5, 1'b1, 5, 100, 0, 0);
    run_test(Stf'($urandom), 3, 1'b1, 3, 100, 0, 0);
    run_test(Stf'($urandom), 6, 1'b1, 6, 100, 10, 5);
    run_test(Stf'($urandom), 0, 1'b1, 0, 100, 0, 0);
    run_test(Stf'($urandom), 3, 1'b1, 2, 100, 0, 0);
    run_test(Stf'($urandom), 2, 1'b1, 2, 100, 0, 0);

    // Abort mid-stream: reset for one cycle once two vectors are out.
    sf_got.delete(); df_got.delete(); res_budget = 8; valid_pct = 100;
    @(posedge clock); #2;
    bus.desc_mux = Stf'($urandom); bus.desc_count = 16'd8; bus.desc_pll = 1'b1;
    bus.desc_valid = 1'b1;
    @(posedge clock); #2;
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 200 && sf_got.size() < 2; i++) begin
      @(negedge clock); #1;
    end
    chk_eq("rst_reached_sent2", sf_got.size(), 2);
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock); #1;
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_ready", bus.desc_ready, 1);
    chk_eq("abort_sfwr", bus.sfifo_wrreq, 0);
    chk_eq("abort_dfwr", bus.dififo_wrreq, 0);
    chk_eq("abort_pll", pll_switch, 0);
    model_pll = 1'b0;
    repeat (10) begin
      @(negedge clock); #1;
    end
    chk_eq("abort_no_more_writes", sf_got.size(), 2);

    run_test(Stf'($urandom), 2, 1'b0, 2, 100, 0, 0);
    for (int t = 0; t < 6; t++) begin
      rc = $urandom_range(1, 12);
      run_test(Stf'($urandom), rc, 1'($urandom_range(0, 1)), rc, 60, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_test_sequencer.md
Name: dut_test_sequencer

Overview:
- Runs one DUT test per descriptor.
- Per test: loads the output-mux configuration into the DUT-interface command FIFO, switches the DUT clock source between base clock and reconfigured PLL clock (with settle delay), streams N stimulus vectors into the stimulus FIFO, then waits until N results have been written to the result FIFO.
- Sits between the host-side test loader and the DUT interface block; the sole writer of its command and stimulus FIFOs.

Parameters:
- STF_WIDTH, 24, stimulus vector / mux mask width
- REQ_WIDTH, 3, request field width of command word
- CMD_WIDTH, 5, command field width of command word
- DIF_WIDTH, REQ_WIDTH+CMD_WIDTH+STF_WIDTH, command FIFO word width
- CNT_WIDTH, 16, vector count width
- SETTLE_CYCLES, 16, clock cycles held after a pll_switch change before streaming
- TIMEOUT_CYCLES, 65535, maximum idle cycles in DRAIN without a new result

Ports:
- clock  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high reset
- desc_valid  in  1  test descriptor valid
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready
- desc_mux  in  STF_WIDTH  mux mask (1 = pin driven by gated clock)
- desc_count  in  CNT_WIDTH  number of vectors N
- desc_pll  in  1  1 = run the DUT from the PLL clock
- dififo_data  out  DIF_WIDTH  command word
- dififo_wrreq  out  1  command FIFO write
- dififo_wrfull  in  1  command FIFO full
- vec_data  in  STF_WIDTH  stimulus source data
- vec_valid  in  1  stimulus source valid
- vec_ready  out  1  stimulus source pop
- sfifo_data  out  STF_WIDTH  stimulus FIFO write data
- sfifo_wrreq  out  1  stimulus FIFO write
- sfifo_wrfull  in  1  stimulus FIFO full
- res_strobe  in  1  one-cycle pulse per result written to result FIFO (monitor of the result FIFO write request)
- pll_switch  out  1  DUT clock source select
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of test
- err_timeout  out  1  sticky; set on DRAIN timeout, cleared on next descriptor accept

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-test aborts immediately with no further FIFO writes.
- FSM states: IDLE, CFG_MUX, SETTLE, STREAM, DRAIN, DONE.
- IDLE:
  - desc_ready=1.
  - On accept: latch mux, count, pll; clear sent/res counters and err_timeout; go to CFG_MUX.
- CFG_MUX:
  - dififo_data = {REQ field 3'b000, CMD field 5'b00001, latched mux}, i.e. upper 8 bits = 8'h01.
  - dififo_wrreq=1 only when !dififo_wrfull. Exactly one write, then go to SETTLE.
- SETTLE:
  - pll_switch <= latched pll on entry.
  - If the value changed: hold SETTLE_CYCLES cycles, else 0 cycles.
  - Then go to STREAM, or to DONE if N==0.
- STREAM:
  - sfifo_wrreq = vec_ready = vec_valid && !sfifo_wrfull && (sent<N); combinational, same cycle.
  - sfifo_data = vec_data.
  - When sent reaches N, go to DRAIN.
- res_strobe is counted in STREAM and DRAIN; the count saturates at N. Extra strobes are ignored. Strobes in IDLE are ignored.
- DRAIN:
  - Go to DONE when res==N.
  - Timeout counter resets on each strobe. If it reaches TIMEOUT_CYCLES: set err_timeout, go to DONE.
- DONE: done=1 for one cycle, then IDLE. pll_switch keeps its last value between tests.
- A strobe on the same cycle as the last vector write is counted.
- A strobe on the same cycle as the timeout expiry counts and wins; no error is raised if it completes N.

Optional Feature:
- Macro: SEQ_STATS_EN.
- When defined: adds output test_cycles [31:0], a counter cleared on descriptor accept that increments every non-IDLE cycle. It is frozen in DONE and IDLE, and saturates at all-ones.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- desc mux=24'h000001, count=4, pll=0, vectors always valid, results strobed 3 cycles after each write -> one dififo write 32'h01000001; 4 sfifo writes matching vec_data; no settle wait; done pulses once; err_timeout=0.
- pll=1 after a pll=0 test -> pll_switch rises on SETTLE entry; first sfifo_wrreq occurs no earlier than 16 cycles later; a repeat test with pll=1 streams with no wait.
- sfifo_wrfull held high for 10 cycles mid-stream, dififo_wrfull high for 5 cycles in CFG_MUX -> no writes while full; total writes still exactly N and 1.
- count=0 -> one dififo write, zero sfifo writes, done asserted with no DRAIN.
- count=3, only 2 res_strobes, TIMEOUT_CYCLES=20 -> done 20 cycles after the last strobe; err_timeout=1, cleared on the next accept.
- Reset asserted for 1 cycle during STREAM with sent=2 -> next cycle: state IDLE, wrreq=0, pll_switch=0, busy=0, desc_ready=1.
